// File: rtl/mdu_mul_ctrl.sv
// Multiply-unit sequencer: issues operands to the external Booth/Wallace multiplier,
// counts out its latency and owns the architectural HI/LO registers.
module mdu_mul_ctrl #(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   input  logic [63:0] mul_result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        gpr_valid,
   output logic [31:0] gpr_data
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAcc} state_e;

   localparam logic [3:0] OpMult  = 4'd0;
   localparam logic [3:0] OpMultu = 4'd1;
   localparam logic [3:0] OpMadd  = 4'd2;
   localparam logic [3:0] OpMaddu = 4'd3;
   localparam logic [3:0] OpMsub  = 4'd4;
   localparam logic [3:0] OpMsubu = 4'd5;
   localparam logic [3:0] OpMthi  = 4'd6;
   localparam logic [3:0] OpMtlo  = 4'd7;
   localparam logic [3:0] OpMul   = 4'd8;

   localparam logic [1:0] LatInit = 2'(MUL_LAT);

   state_e      state_q;
   logic [3:0]  op_q;
   logic [1:0]  cnt_q;
   logic [63:0] prod_q;

   logic        accept;
   logic        start_mul;
   logic        start_signed;
   logic        op_is_acc;
   logic        op_is_sub;
   logic [63:0] acc_sum;
   logic [63:0] acc_diff;

   assign op_ready = (state_q == StIdle) & ~flush;
   assign busy     = (state_q != StIdle);
   assign accept   = op_valid & op_ready;

   always_comb begin
      start_mul    = 1'b0;
      start_signed = 1'b0;
      case (op_code)
         OpMult, OpMadd, OpMsub, OpMul: begin
            start_mul    = 1'b1;
            start_signed = 1'b1;
         end
         OpMultu, OpMaddu, OpMsubu: start_mul = 1'b1;
         default: ;
      endcase
   end

   assign op_is_acc = (op_q == OpMadd) | (op_q == OpMaddu) | (op_q == OpMsub) |
                      (op_q == OpMsubu);
   assign op_is_sub = (op_q == OpMsub) | (op_q == OpMsubu);

   // Accumulate wraps modulo 2^64; MADD/MSUB raise no overflow.
   assign acc_sum  = {hi, lo} + prod_q;
   assign acc_diff = {hi, lo} - prod_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StIdle;
         op_q      <= 4'd0;
         cnt_q     <= 2'd0;
         prod_q    <= 64'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         mul_a     <= 32'd0;
         mul_b     <= 32'd0;
         mul_sign  <= 1'b0;
         gpr_valid <= 1'b0;
         gpr_data  <= 32'd0;
      end else begin
         gpr_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (start_mul) begin
                     mul_a    <= op_a;
                     mul_b    <= op_b;
                     mul_sign <= start_signed;
                     op_q     <= op_code;
                     cnt_q    <= LatInit;
                     state_q  <= StIssue;
                  end else if (op_code == OpMthi) begin
                     hi <= op_a;
                  end else if (op_code == OpMtlo) begin
                     lo <= op_a;
                  end
               end
            end
            StIssue: begin
               state_q <= flush ? StIdle : StWait;
            end
            StWait: begin
               if (flush) begin
                  state_q <= StIdle;
               end else if (cnt_q == 2'd1) begin
                  if (op_q == OpMul) begin
                     gpr_data  <= mul_result[31:0];
                     gpr_valid <= 1'b1;
                     state_q   <= StIdle;
                  end else if (op_is_acc) begin
                     prod_q  <= mul_result;
                     state_q <= StAcc;
                  end else begin
                     {hi, lo} <= mul_result;
                     state_q  <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            StAcc: begin
               if (!flush) begin
                  {hi, lo} <= op_is_sub ? acc_diff : acc_sum;
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mdu_mul_ctrl.md
Name: mdu_mul_ctrl

Overview:
- Sequencing controller for the pipelined Booth/Wallace 32x32 multiplier in the CPU's multiply unit.
- Accepts multiply-class instructions from execute and drives the multiplier operand and sign inputs.
- Counts out the multiplier latency and owns the architectural HI/LO registers.
- Supports MIPS MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO/MUL, with pipeline flush on exception.

Parameters:
- MUL_LAT, 1, cycles from multiplier operands valid to mul_result valid. Legal values: 1, or 2 when the multiplier's second barrier stage is enabled.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- op_valid  in  1  instruction offered
- op_ready  out  1  controller can accept; handshake when op_valid&op_ready
- op_code  in  4  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MTHI, 7 MTLO, 8 MUL, 9-15 NOP
- op_a  in  32  rs value
- op_b  in  32  rt value
- flush  in  1  kill any in-flight or offered op
- mul_a  out  32  multiplier A (registered)
- mul_b  out  32  multiplier B (registered)
- mul_sign  out  1  1 = signed multiply (registered)
- mul_result  in  64  multiplier product
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- busy  out  1  op in flight; MFHI/MFLO must stall while high
- gpr_valid  out  1  one-cycle pulse: MUL result ready
- gpr_data  out  32  MUL result (low 32 bits of product)

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; hi, lo, mul_a, mul_b = 0; mul_sign, gpr_valid, gpr_data = 0. Reset mid-operation discards the op; no HI/LO write.
- op_ready = (state==IDLE) & ~flush. busy = (state!=IDLE).
- States: IDLE, ISSUE, WAIT, ACC.
- IDLE, accept of op 0-5 or 8:
  - latch op_a to mul_a and op_b to mul_b.
  - mul_sign = 1 for codes 0, 2, 4, 8; 0 otherwise.
  - latch op_code; counter = MUL_LAT; go to ISSUE.
- IDLE, accept of MTHI/MTLO: hi (or lo) = op_a at the accept edge, visible next cycle; stay IDLE.
- IDLE, accept of NOP code: no effect; stay IDLE.
- ISSUE (1 cycle): operands are presented to the multiplier; go to WAIT.
- WAIT:
  - Decrement counter each cycle while counter != 1.
  - When counter == 1, mul_result is valid this cycle:
    - MULT/MULTU: {hi,lo} = mul_result; go to IDLE.
    - MUL: gpr_data = mul_result[31:0]; gpr_valid = 1 next cycle only; HI/LO unchanged; go to IDLE.
    - MADD*/MSUB*: product registered into internal 64-bit prod_q; go to ACC.
- ACC (1 cycle): {hi,lo} = {hi,lo} + prod_q (MADD*) or {hi,lo} - prod_q (MSUB*), modulo 2^64, no overflow flag; go to IDLE.
- Latency, MULT, MUL_LAT=1:
  - accept in cycle 0, ISSUE cycle 1, WAIT cycle 2.
  - hi/lo new value visible cycle 3; next op accepted cycle 3.
  - MADD/MSUB add one cycle; MUL_LAT=2 adds one cycle.
- Flush:
  - flush high in any cycle with state != IDLE: next state IDLE; no HI/LO/prod_q write and no gpr_valid, including when flush coincides with the WAIT-final or ACC cycle.
  - flush in the same cycle as op_valid: not accepted.
  - MTHI/MTLO are only written when accepted, so flush blocks them too.
- mul_a/mul_b/mul_sign hold their values until the next accept; they do not change mid-op.
- gpr_valid is never high while busy is low except for the single completion pulse cycle.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, MUL_LAT=1 -> busy high cycles 1-2; cycle 3 hi=0xFFFFFFFF lo=0xFFFFFFFE; op_ready high cycle 3.
- MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE; mul_sign=0 during op.
- MTHI 0x0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=0x00000001 lo=0x00000000, one cycle after the MULT-equivalent timing. MSUBU 1*1 from hi=lo=0 -> hi=lo=0xFFFFFFFF (wrap).
- MUL a=7 b=0xFFFFFFFD -> single gpr_valid pulse with gpr_data=0xFFFFFFEB; hi/lo unchanged from prior values.
- MULT accepted, flush asserted in the WAIT-final cycle -> hi/lo unchanged, busy low next cycle. op_valid with flush=1 in IDLE -> op_ready=0, nothing written.
- Repeat MULT with MUL_LAT=2 -> result visible cycle 4. Assert resetn=0 during WAIT -> hi=lo=0, busy=0, gpr_valid=0 after the edge.
